// File: rtl/alu_main_control_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_main_control_pkg
// Brief   : Shared encodings for the multicycle main controller.
// Revision: 1.0 - initial release
// ============================================================================
package alu_main_control_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [2:0] F3_LDSD  = 3'b011;
   localparam logic [2:0] F3_BEQ   = 3'b000;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_REG   = 2'd2;
   localparam logic [1:0] SRCB_REG   = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;

   typedef logic [3:0] state_t;
   localparam state_t ST_FETCH    = 4'd0;
   localparam state_t ST_DECODE   = 4'd1;
   localparam state_t ST_EXEC_R   = 4'd2;
   localparam state_t ST_MEM_ADDR = 4'd3;
   localparam state_t ST_MEM_RD   = 4'd4;
   localparam state_t ST_MEM_WB   = 4'd5;
   localparam state_t ST_MEM_WR   = 4'd6;
   localparam state_t ST_R_WB     = 4'd7;
   localparam state_t ST_BRANCH   = 4'd8;
   localparam state_t ST_HALT     = 4'd9;

endpackage
`default_nettype wire

// File: rtl/alu_main_control_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_control_decode
// Brief   : Maps R-type {funct7, funct3} to an ALU operation plus valid flag.
// Revision: 1.0 - initial release
// ============================================================================
module alu_control_decode
   import alu_main_control_pkg::*;
(
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output logic [3:0] alu_ctrl,
   output logic       valid
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      valid    = 1'b1;
      case ({funct7, funct3})
         {7'b0000000, 3'b000}: alu_ctrl = ALU_ADD;
         {7'b0100000, 3'b000}: alu_ctrl = ALU_SUB;
         {7'b0000000, 3'b111}: alu_ctrl = ALU_AND;
         {7'b0000000, 3'b110}: alu_ctrl = ALU_OR;
         default:              valid    = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_main_control.sv
`default_nettype none
// ============================================================================
// Module  : alu_main_control
// Brief   : Multicycle main controller FSM (R-type, ld, sd, beq).
// Revision: 1.0 - initial release
// ============================================================================
module alu_main_control
   import alu_main_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] alu_ctrl,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       ir_write,
   output logic       pc_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       pc_src,
   output logic       illegal
);

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [3:0] dec_ctrl;
   logic       dec_valid;
   logic       en_ir, en_pc, en_mrd, en_mwr, en_reg;

   alu_control_decode u_dec (
      .funct7   (funct7),
      .funct3   (funct3),
      .alu_ctrl (dec_ctrl),
      .valid    (dec_valid)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = ST_EXEC_R;
               OP_LD, OP_SD: state_d = (funct3 == F3_LDSD) ? ST_MEM_ADDR : ST_HALT;
               OP_BEQ:       state_d = (funct3 == F3_BEQ) ? ST_BRANCH : ST_HALT;
               default:      state_d = ST_HALT;
            endcase
         end
         ST_EXEC_R:   state_d = dec_valid ? ST_R_WB : ST_HALT;
         ST_R_WB:     state_d = ST_FETCH;
         ST_MEM_ADDR: state_d = (opcode == OP_LD) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WB:   state_d = ST_FETCH;
         ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
         ST_BRANCH:   state_d = ST_FETCH;
         ST_HALT:     state_d = ST_HALT;
         default:     state_d = ST_HALT;
      endcase
   end

   assign illegal_d = illegal_q | (state_d == ST_HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      alu_ctrl   = ALU_ADD;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_REG;
      en_ir      = 1'b0;
      en_pc      = 1'b0;
      en_mrd     = 1'b0;
      en_mwr     = 1'b0;
      en_reg     = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            en_mrd    = 1'b1;
            alu_src_b = SRCB_FOUR;
            en_ir     = mem_ready;
            en_pc     = mem_ready;
         end
         ST_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         ST_EXEC_R: begin
            alu_src_a = SRCA_REG;
            alu_ctrl  = dec_ctrl;
         end
         ST_R_WB:     en_reg = 1'b1;
         ST_MEM_ADDR: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
         end
         ST_MEM_RD:   en_mrd = 1'b1;
         ST_MEM_WB: begin
            en_reg     = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEM_WR:   en_mwr = 1'b1;
         ST_BRANCH: begin
            alu_src_a = SRCA_REG;
            alu_ctrl  = ALU_SUB;
            pc_src    = 1'b1;
            en_pc     = zero;
         end
         default: ;
      endcase
   end

   // Enables are forced low while reset is held so no write escapes mid-wait.
   assign ir_write  = en_ir  & ~rst;
   assign pc_write  = en_pc  & ~rst;
   assign mem_read  = en_mrd & ~rst;
   assign mem_write = en_mwr & ~rst;
   assign reg_write = en_reg & ~rst;
   assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_main_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_main_control
// Brief   : Directed scoreboard bench for the multicycle main controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_main_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       zero;
   logic       mem_ready;
   logic [3:0] alu_ctrl;
   logic [1:0] alu_src_a, alu_src_b;
   logic       ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg, pc_src, illegal;

   typedef struct {
      logic [15:0] v;
      logic [15:0] m;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   alu_main_control dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7     (funct7),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .alu_ctrl   (alu_ctrl),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .pc_src     (pc_src),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // flags: {ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg, pc_src, illegal}
   function automatic logic [15:0] ov(input logic [3:0] c, input logic [1:0] a,
                                      input logic [1:0] b, input logic [7:0] f);
      return {c, a, b, f};
   endfunction

   localparam logic [15:0] M_ALL  = 16'hFFFB;
   localparam logic [15:0] M_ALU  = 16'hFFF9;
   localparam logic [15:0] M_WB   = 16'h00FD;
   localparam logic [15:0] M_EN   = 16'h00F9;
   localparam logic [15:0] M_EXBAD = 16'h0FF9;

   task automatic cyc(input string nm, input logic [15:0] v, input logic [15:0] m);
      exp_t e;
      e.v = v; e.m = m; e.nm = nm;
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic fetch(input string nm);
      mem_ready = 1'b1;
      cyc({nm, "_fetch"}, ov(4'b0010, 2'd0, 2'd1, 8'b1110_0000), M_ALL);
      cyc({nm, "_decode"}, ov(4'b0010, 2'd1, 2'd2, 8'b0000_0000), M_ALU);
   endtask

   task automatic do_r(input string nm, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [3:0] code);
      opcode = 7'b0110011; funct7 = f7; funct3 = f3;
      fetch(nm);
      cyc({nm, "_exec"}, ov(code, 2'd2, 2'd0, 8'b0000_0000), M_ALU);
      cyc({nm, "_rwb"}, ov(4'b0010, 2'd0, 2'd0, 8'b0000_1000), M_WB);
   endtask

   task automatic do_beq(input string nm, input logic z);
      opcode = 7'b1100011; funct7 = 7'd0; funct3 = 3'b000; zero = z;
      fetch(nm);
      cyc({nm, "_branch"}, ov(4'b0110, 2'd2, 2'd0, {1'b0, z, 6'b00_0010}), M_ALL);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor: every cycle the DUT presents a response that the scoreboard consumes.
   always @(negedge clk) begin
      logic [15:0] act;
      exp_t e;
      act = {alu_ctrl, alu_src_a, alu_src_b, ir_write, pc_write, mem_read, mem_write,
             reg_write, mem_to_reg, pc_src, illegal};
      if (q.size() != 0) begin
         e = q.pop_front();
         n_checks++;
         if ((act & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", e.nm, act, e.v, e.m, $time);
         end
      end
      if (rst === 1'b0) begin
         n_checks++;
         if ((mem_read & mem_write) !== 1'b0 || (reg_write & pc_write) !== 1'b0) begin
            n_errors++;
            $display("FAIL exclusive_enables: got rd=%b wr=%b rw=%b pw=%b expected no overlap at %0t",
                     mem_read, mem_write, reg_write, pc_write, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      do_r("add", 7'b0000000, 3'b000, 4'b0010);
      do_r("sub", 7'b0100000, 3'b000, 4'b0110);
      do_r("and", 7'b0000000, 3'b111, 4'b0000);
      do_r("or",  7'b0000000, 3'b110, 4'b0001);

      do_beq("beq_taken", 1'b1);
      do_beq("beq_not", 1'b0);
      zero = 1'b0;

      // ld with three memory wait states: 8 cycles total
      opcode = 7'b0000011; funct3 = 3'b011; funct7 = 7'd0;
      fetch("ld");
      cyc("ld_addr", ov(4'b0010, 2'd2, 2'd2, 8'b0000_0000), M_ALU);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("ld_wait", ov(4'b0010, 2'd0, 2'd0, 8'b0010_0000), M_EN);
      mem_ready = 1'b1;
      cyc("ld_rd", ov(4'b0010, 2'd0, 2'd0, 8'b0010_0000), M_EN);
      cyc("ld_wb", ov(4'b0010, 2'd0, 2'd0, 8'b0000_1100), M_WB);

      // sd with no wait states: 4 cycles
      opcode = 7'b0100011;
      fetch("sd");
      cyc("sd_addr", ov(4'b0010, 2'd2, 2'd2, 8'b0000_0000), M_ALU);
      cyc("sd_wr", ov(4'b0010, 2'd0, 2'd0, 8'b0001_0000), M_EN);

      // unsupported opcode halts and stays halted until reset
      opcode = 7'b1111111; funct3 = 3'd0;
      fetch("bad_op");
      for (int i = 0; i < 12; i++) cyc("halt_op", ov(4'b0010, 2'd0, 2'd0, 8'b0000_0001), M_EN);
      pulse_reset();
      do_r("add_after_rst", 7'b0000000, 3'b000, 4'b0010);

      // unsupported R-type function halts after EXEC_R
      opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = 3'b000;
      fetch("bad_funct");
      cyc("bad_funct_exec", ov(4'b0000, 2'd2, 2'd0, 8'b0000_0000), M_EXBAD);
      for (int i = 0; i < 3; i++) cyc("halt_funct", ov(4'b0010, 2'd0, 2'd0, 8'b0000_0001), M_EN);
      pulse_reset();

      // reset while sd waits on memory
      opcode = 7'b0100011; funct3 = 3'b011; funct7 = 7'd0;
      fetch("sd_rst");
      cyc("sd_rst_addr", ov(4'b0010, 2'd2, 2'd2, 8'b0000_0000), M_ALU);
      mem_ready = 1'b0;
      cyc("sd_rst_wait", ov(4'b0010, 2'd0, 2'd0, 8'b0001_0000), M_EN);
      cyc("sd_rst_wait", ov(4'b0010, 2'd0, 2'd0, 8'b0001_0000), M_EN);
      pulse_reset();
      cyc("post_rst_fetch", ov(4'b0010, 2'd0, 2'd1, 8'b0010_0000), M_ALL);
      do_r("or_final", 7'b0000000, 3'b110, 4'b0001);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_main_control.md
ALU_MAIN_CONTROL -- requirements
Module: alu_main_control

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port list SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  instruction bits [6:0] from the instruction register
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  instruction bits [31:25]
- zero  in  1  ALU zero flag; 1 when the ALU result is 0
- mem_ready  in  1  memory handshake; 1 when a read or write completes this cycle
- alu_ctrl  out  4  ALU operation code
- alu_src_a  out  2  ALU A-operand select: 0 = PC, 1 = old PC, 2 = register A
- alu_src_b  out  2  ALU B-operand select: 0 = register B, 1 = constant 4, 2 = immediate
- ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg, pc_src  out  1 each  datapath enables and selects
- illegal  out  1  sticky unsupported-instruction flag

Function
REQ-003 alu_ctrl encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB; no other value is ever driven.
REQ-004 The FSM SHALL implement these states: FETCH, DECODE, EXEC_R, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_WB, BRANCH, HALT.
REQ-005 All outputs SHALL be Moore outputs decoded from the state register only, with two exceptions: pc_write in BRANCH and the mem_ready qualification defined below.
REQ-006 FETCH SHALL behave as follows:
- drive mem_read=1, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_src=0
- when mem_ready=1: pulse ir_write=1 and pc_write=1, then go to DECODE
- otherwise: stay in FETCH, with ir_write=0 and pc_write=0
REQ-007 DECODE SHALL drive alu_src_a=1, alu_src_b=2, alu_ctrl=ADD, which precomputes the branch target into ALUOut.
REQ-008 DECODE SHALL dispatch on opcode:
- 0110011 -> EXEC_R
- 0000011 (ld, funct3=011) -> MEM_ADDR
- 0100011 (sd, funct3=011) -> MEM_ADDR
- 1100011 (beq, funct3=000) -> BRANCH
- anything else -> HALT
REQ-009 EXEC_R SHALL drive alu_src_a=2 and alu_src_b=0, with alu_ctrl selected from {funct7, funct3}:
- 0000000/000 -> ADD
- 0100000/000 -> SUB
- 0000000/111 -> AND
- 0000000/110 -> OR
- any other combination -> HALT on the next edge
REQ-010 R_WB SHALL pulse reg_write=1 with mem_to_reg=0 for exactly one cycle, then go to FETCH.
REQ-011 MEM_ADDR SHALL drive alu_src_a=2, alu_src_b=2, alu_ctrl=ADD, then go to MEM_RD for ld or MEM_WR for sd.
REQ-012 MEM_RD and MEM_WR SHALL hold mem_read and mem_write respectively for every cycle until mem_ready=1; then go to MEM_WB (ld) or FETCH (sd).
REQ-013 MEM_WB SHALL pulse reg_write=1 with mem_to_reg=1 for one cycle, then go to FETCH.
REQ-014 BRANCH SHALL:
- drive alu_src_a=2, alu_src_b=0, alu_ctrl=SUB, pc_src=1
- set pc_write=zero combinationally
- go to FETCH unconditionally
REQ-015 HALT SHALL set illegal=1, hold all enables at 0, and remain in HALT until rst.
REQ-016 Per-instruction latency with zero memory wait states SHALL be: R-type 4 cycles, ld 5, sd 4, beq 3; each wait state adds 1 cycle.
REQ-017 mem_read and mem_write SHALL never be asserted in the same cycle; reg_write and pc_write SHALL never be asserted in the same cycle.

Reset
REQ-018 When rst=1 at a clock edge, the state SHALL become FETCH, illegal SHALL become 0, and all enables SHALL be 0 in that cycle. This applies in any state, including mid-wait in MEM_RD/MEM_WR and in HALT.
REQ-019 In the first cycle after reset deassertion, the block SHALL be in FETCH with mem_read=1.

Structure
REQ-020 A shared package SHALL hold:
- the state enum
- the alu_ctrl constants (AND, OR, ADD, SUB)
- the opcode constants
- the operand-select constants
REQ-021 Decoding of {funct7, funct3} to alu_ctrl SHALL be a combinational sub-module named alu_control_decode, which outputs alu_ctrl and a valid flag.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add (funct7=0000000, funct3=000), mem_ready tied to 1 -> state sequence FETCH, DECODE, EXEC_R, R_WB; alu_ctrl=0010 in EXEC_R; one reg_write pulse with mem_to_reg=0.
- sub (funct7=0100000) -> alu_ctrl=0110 in EXEC_R. and (funct3=111) -> 0000. or (funct3=110) -> 0001.
- beq with zero=1 -> pc_write=1 and pc_src=1 in BRANCH. Repeat with zero=0 -> pc_write=0. Both cases return to FETCH after 3 cycles total.
- ld with mem_ready low for 3 cycles in MEM_RD -> mem_read held 3+1 cycles; reg_write with mem_to_reg=1 exactly once; 8 cycles total.
- opcode 1111111 -> HALT after DECODE; illegal=1 and stays 1 for 10 or more cycles; rst=1 -> FETCH and illegal=0 on the next edge.
- rst asserted while in MEM_WR waiting -> next cycle is FETCH with mem_write=0; no spurious pc_write or reg_write.
